spi_slave_burst: RTL and testbench



---
 rtl/spi_slave_burst.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst.sv
// SPI slave bridging a system-clock-sampled serial master to a single-port memory.
// Frames are command bit, address, then bursts of write or read words with auto-incrementing address.
module spi_slave_burst #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int TA_CYCLES = 2,
  parameter int BURST_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_miss
);

  localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_W  = (MAX_AD > TA_CYCLES) ? MAX_AD : TA_CYCLES;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_miss_q, rd_miss_d;
  logic              load_word;

  // A read word starts at the end of turnaround and, in burst mode, at every word boundary.
  always_comb begin
    load_word = !SS_n &&
                (((state_q == S_TURN) && (cnt_q == TA_LAST)) ||
                 ((state_q == S_RDATA) && (cnt_q == DATA_LAST) && (BURST_EN != 0)));
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_miss_d  = 1'b0;

    if ((state_q != S_IDLE) && rd_valid) begin
      buf_d      = rd_data;
      buf_full_d = 1'b1;
    end

    if (SS_n) begin
      state_d    = S_IDLE;
      cmd_d      = 1'b0;
      cnt_d      = '0;
      addr_d     = '0;
      rx_d       = '0;
      tx_d       = '0;
      buf_d      = '0;
      buf_full_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d   = MOSI;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = (addr_q << 1) | ADDR_W'(MOSI);
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (cmd_q) begin
              state_d   = S_TURN;
              rd_req_d  = 1'b1;
              rd_addr_d = addr_d;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WDATA: begin
          rx_d = (rx_q << 1) | DATA_W'(MOSI);
          if (cnt_q == DATA_LAST) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_d;
            addr_d    = addr_q + ADDR_W'(1);
            cnt_d     = '0;
            if (BURST_EN == 0) begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_TURN: begin
          if (cnt_q == TA_LAST) begin
            cnt_d   = '0;
            state_d = S_RDATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RDATA: begin
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (BURST_EN == 0) begin
              state_d = S_DONE;
              tx_d    = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            tx_d  = tx_q << 1;
          end
        end
        S_DONE: begin
          tx_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Buffered data is older than anything arriving now; otherwise data landing on this edge is used directly.
      if (load_word) begin
        if (buf_full_q) begin
          tx_d       = buf_q;
          buf_full_d = rd_valid;
        end else if (rd_valid) begin
          tx_d       = rd_data;
          buf_full_d = 1'b0;
        end else begin
          tx_d       = '0;
          rd_miss_d  = 1'b1;
          buf_full_d = 1'b0;
        end
        if (BURST_EN != 0) begin
          addr_d    = addr_q + ADDR_W'(1);
          rd_req_d  = 1'b1;
          rd_addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_miss_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_miss_q  <= rd_miss_d;
    end
  end

  assign MISO    = tx_q[DATA_W-1];
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign rd_miss = rd_miss_q;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: directed and random frames against an edge-indexed reference model.
module tb_spi_slave_burst;
  localparam int A  = 8;
  localparam int D  = 8;
  localparam int TA = 2;

  logic       clk, rst, SS_n, MOSI, MISO;
  logic       wr_en, rd_req, rd_valid, rd_miss;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  logic [7:0] mem [256];
  logic [7:0] wq [4];
  int         lat;
  bit         mem_on;
  bit         pend;
  logic [7:0] pend_addr;
  int         total, passed;

  spi_slave_burst #(.ADDR_W(A), .DATA_W(D), .TA_CYCLES(TA), .BURST_EN(1)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_miss(rd_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge, then play the memory: answers each request after 'lat' cycles.
  task automatic step();
    @(negedge clk);
    if (pend) begin
      rd_valid = 1'b1;
      rd_data  = mem[pend_addr];
      pend     = 1'b0;
    end else if (rd_req && mem_on && lat == 0) begin
      rd_valid = 1'b1;
      rd_data  = mem[rd_addr];
    end else begin
      rd_valid = 1'b0;
      rd_data  = 8'($urandom);
    end
    if (rd_req && mem_on && lat == 1) begin
      pend      = 1'b1;
      pend_addr = rd_addr;
    end
  endtask

  // Drives one frame for L edges after E0, checking every output after each edge.
  task automatic run_frame(input bit cmd, input logic [7:0] a, input int nbits,
                           input bit do_rst, input bit spur);
    int         L, j, k, off, b;
    logic       ew, er, em, eo;
    logic [7:0] ewa, ewd, era, word, ai;
    L = cmd ? (A + TA + nbits) : (1 + A + nbits);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    if (spur) begin
      rd_valid = 1'b1;
      rd_data  = 8'hC3;
    end
    step();
    for (int n = 1; n <= L; n++) begin
      if (n == 1) MOSI = cmd;
      else if (n <= 1 + A) MOSI = a[A - 1 - (n - 2)];
      else if (!cmd) begin
        j = n - 2 - A;
        MOSI = wq[j / D][D - 1 - (j % D)];
      end else MOSI = 1'($urandom);
      step();
      ew = 0; er = 0; em = 0; eo = 0; ewa = 0; ewd = 0; era = 0;
      if (!cmd) begin
        if (n >= 1 + A + D && (n - 1 - A) % D == 0) begin
          k   = (n - 1 - A) / D - 1;
          ew  = 1;
          ewa = a + 8'(k);
          ewd = wq[k];
        end
      end else begin
        if (n == 1 + A) begin
          er  = 1;
          era = a;
        end
        if (n >= 1 + A + TA) begin
          off  = n - 1 - A - TA;
          k    = off / D;
          b    = off % D;
          ai   = a + 8'(k);
          word = mem_on ? mem[ai] : 8'h00;
          eo   = word[D - 1 - b];
          if (b == 0) begin
            er  = 1;
            era = a + 8'(k + 1);
            em  = !mem_on;
          end
        end
      end
      chk("wr_en", wr_en, ew);
      chk("rd_req", rd_req, er);
      chk("rd_miss", rd_miss, em);
      chk("MISO", MISO, eo);
      if (ew) begin
        chk("wr_addr", wr_addr, ewa);
        chk("wr_data", wr_data, ewd);
      end
      if (er) chk("rd_addr", rd_addr, era);
    end
    if (do_rst) begin
      rst = 1'b1;
      step();
      chk("rst_MISO", MISO, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_miss", rd_miss, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      rst  = 1'b0;
      SS_n = 1'b1;
      step();
    end else begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      step();
      chk("end_MISO", MISO, 0);
      chk("end_wr_en", wr_en, 0);
      chk("end_rd_req", rd_req, 0);
      chk("end_rd_miss", rd_miss, 0);
    end
    step();
    pend = 1'b0;
    $display("frame cmd=%0d addr=0x%02h bits=%0d rst=%0d checks=%0d passed=%0d",
             cmd, a, nbits, do_rst, total, passed);
  endtask

  initial begin
    int         words;
    bit         c;
    logic [7:0] ra;
    total = 0; passed = 0;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    pend = 1'b0; pend_addr = 8'h00; lat = 1; mem_on = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) wq[i] = 8'h00;

    step();
    step();
    chk("reset_MISO", MISO, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_miss", rd_miss, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_rd_addr", rd_addr, 0);
    rst = 1'b0;
    step();

    wq[0] = 8'hA5;
    run_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0);

    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    run_frame(1'b0, 8'hFE, 24, 1'b0, 1'b0);

    mem[8'h10] = 8'h5A; lat = 1;
    run_frame(1'b1, 8'h10, 8, 1'b0, 1'b0);

    mem[8'h20] = 8'h81; mem[8'h21] = 8'h7E; lat = 0;
    run_frame(1'b1, 8'h20, 16, 1'b0, 1'b0);

    lat = 1;
    run_frame(1'b1, 8'hFF, 16, 1'b0, 1'b0);

    mem_on = 1'b0;
    run_frame(1'b1, 8'h40, 8, 1'b0, 1'b0);
    run_frame(1'b1, 8'h41, 8, 1'b0, 1'b1);
    mem_on = 1'b1;

    wq[0] = 8'hF0;
    run_frame(1'b0, 8'h55, 4, 1'b0, 1'b0);
    wq[0] = 8'h0F;
    run_frame(1'b0, 8'h56, 8, 1'b0, 1'b0);

    run_frame(1'b1, 8'h77, 5, 1'b1, 1'b0);

    for (int t = 0; t < 10; t++) begin
      c     = 1'($urandom);
      ra    = 8'($urandom);
      words = $urandom_range(1, 3);
      lat   = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) wq[i] = 8'($urandom);
      if (!c && $urandom_range(0, 3) == 0)
        run_frame(c, ra, words * D - $urandom_range(1, D - 1), 1'b0, 1'b0);
      else
        run_frame(c, ra, words * D, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
